game_seq_ctrl: RTL and testbench

//  Match sequencer for the two-player paddle game driven by L_swt/R_swt.

---
 rtl/game_pkg.sv | 23 ++
 rtl/frame_timer.sv | 31 +++
 rtl/game_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_game_seq_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the paddle-game match sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_e;

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_LEFT  = 2'b01;
    localparam logic [1:0] WINNER_RIGHT = 2'b10;

    localparam int WIN_SCORE_DEF = 9;

    // Saturating BCD-digit increment: a score never passes the winning value.
    function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
        return (val >= lim) ? lim : val + 4'd1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame countdown: load N-1 on state entry, done fires on the tick that finds zero,
// so exactly N ticks are spent in the timed state.
module frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] cnt_r;

    // Countdown register; load has priority over a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (tick && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = tick & (cnt_r == '0);

endmodule

// File: rtl/game_seq_ctrl.sv
// Match sequencer for the two-player paddle game: serve/play/freeze sequencing,
// score keeping and winner reporting, all on a frame_tick time base.
module game_seq_ctrl
    import game_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SERVE_FRAMES = 60,
    parameter int HOLD_FRAMES  = 90,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       game_rst,
    input  logic       frame_tick,
    input  logic       L_swt,
    input  logic       R_swt,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       play_en,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic [2:0] state_o
);

    localparam logic [3:0]       WIN_VAL  = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_FRAMES - 1);

    state_e           state_r, state_nxt_s;
    logic [3:0]       score_l_r, score_l_nxt_s;
    logic [3:0]       score_r_r, score_r_nxt_s;
    logic [1:0]       winner_r, winner_nxt_s;
    logic             serve_dir_r, serve_dir_nxt_s;
    logic             play_en_r, ball_reset_r;
    logic             start_q_r;
    logic             start_pulse_s;
    logic             tick_s, done_s, load_s;
    logic [CNT_W-1:0] load_val_s;

    assign start_pulse_s = L_swt & R_swt & ~start_q_r;
    assign tick_s        = frame_tick & ((state_r == SERVE) || (state_r == POINT));

    frame_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (game_rst),
        .load     (load_s),
        .load_val (load_val_s),
        .tick     (tick_s),
        .done     (done_s)
    );

    // Next-state, score and winner decisions.
    always_comb begin
        state_nxt_s     = state_r;
        score_l_nxt_s   = score_l_r;
        score_r_nxt_s   = score_r_r;
        winner_nxt_s    = winner_r;
        serve_dir_nxt_s = serve_dir_r;
        load_s          = 1'b0;
        load_val_s      = '0;
        case (state_r)
            IDLE, OVER: begin
                if (start_pulse_s) begin
                    state_nxt_s     = SERVE;
                    score_l_nxt_s   = 4'd0;
                    score_r_nxt_s   = 4'd0;
                    winner_nxt_s    = WINNER_NONE;
                    serve_dir_nxt_s = 1'b0;
                    load_s          = 1'b1;
                    load_val_s      = SERVE_LD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            SERVE: begin
                if (done_s) begin
                    state_nxt_s = PLAY;
                end else begin
                    state_nxt_s = SERVE;
                end
            end
            PLAY: begin
                // A double miss is a replay; a miss always beats a same-cycle tick.
                if (miss_l && miss_r) begin
                    state_nxt_s = SERVE;
                    load_s      = 1'b1;
                    load_val_s  = SERVE_LD;
                end else if (miss_l) begin
                    score_r_nxt_s   = sat_inc(score_r_r, WIN_VAL);
                    serve_dir_nxt_s = 1'b0;
                    state_nxt_s     = POINT;
                    load_s          = 1'b1;
                    load_val_s      = HOLD_LD;
                end else if (miss_r) begin
                    score_l_nxt_s   = sat_inc(score_l_r, WIN_VAL);
                    serve_dir_nxt_s = 1'b1;
                    state_nxt_s     = POINT;
                    load_s          = 1'b1;
                    load_val_s      = HOLD_LD;
                end else begin
                    state_nxt_s = PLAY;
                end
            end
            POINT: begin
                if (done_s) begin
                    if ((score_l_r == WIN_VAL) || (score_r_r == WIN_VAL)) begin
                        state_nxt_s  = OVER;
                        winner_nxt_s = (score_l_r == WIN_VAL) ? WINNER_LEFT : WINNER_RIGHT;
                    end else begin
                        state_nxt_s = SERVE;
                        load_s      = 1'b1;
                        load_val_s  = SERVE_LD;
                    end
                end else begin
                    state_nxt_s = POINT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, score and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (game_rst) begin
            state_r      <= IDLE;
            score_l_r    <= 4'd0;
            score_r_r    <= 4'd0;
            winner_r     <= WINNER_NONE;
            serve_dir_r  <= 1'b0;
            start_q_r    <= 1'b1;
            play_en_r    <= 1'b0;
            ball_reset_r <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            score_l_r    <= score_l_nxt_s;
            score_r_r    <= score_r_nxt_s;
            winner_r     <= winner_nxt_s;
            serve_dir_r  <= serve_dir_nxt_s;
            start_q_r    <= L_swt & R_swt;
            play_en_r    <= (state_nxt_s == PLAY);
            ball_reset_r <= (state_nxt_s != PLAY);
        end
    end

    assign play_en    = play_en_r;
    assign ball_reset = ball_reset_r;
    assign serve_dir  = serve_dir_r;
    assign score_l    = score_l_r;
    assign score_r    = score_r_r;
    assign winner     = winner_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed bench for game_seq_ctrl with short frame counts and WIN_SCORE=2.
module tb_game_seq_ctrl;

    logic       clk = 1'b0;
    logic       game_rst, frame_tick, L_swt, R_swt, miss_l, miss_r;
    logic       play_en, ball_reset, serve_dir;
    logic [3:0] score_l, score_r;
    logic [1:0] winner;
    logic [2:0] state_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

    game_seq_ctrl #(
        .WIN_SCORE    (2),
        .SERVE_FRAMES (3),
        .HOLD_FRAMES  (2),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .game_rst   (game_rst),
        .frame_tick (frame_tick),
        .L_swt      (L_swt),
        .R_swt      (R_swt),
        .miss_l     (miss_l),
        .miss_r     (miss_r),
        .play_en    (play_en),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .score_l    (score_l),
        .score_r    (score_r),
        .winner     (winner),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vec_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: nine quiet cycles then a one-cycle tick; returns after the tick is sampled.
    task automatic frame();
        repeat (9) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        @(negedge clk);
        miss_l = l;
        miss_r = r;
        @(negedge clk);
        miss_l = 1'b0;
        miss_r = 1'b0;
    endtask

    task automatic restart();
        @(negedge clk);
        L_swt = 1'b0;
        R_swt = 1'b0;
        @(negedge clk);
        L_swt = 1'b1;
        R_swt = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        game_rst = 1'b1; frame_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        L_swt = 1'b1; R_swt = 1'b1;
        repeat (2) @(negedge clk);
        game_rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: switches held through reset do not start a match
        chk("rst_state", state_o, S_IDLE);
        chk("rst_ball_reset", ball_reset, 1);
        chk("rst_play_en", play_en, 0);
        chk("rst_score_l", score_l, 0);
        chk("rst_winner", winner, 0);
        restart();
        chk("start_state", state_o, S_SERVE);

        // 2: play_en rises right after the third tick
        frame();
        chk("serve_t1_play_en", play_en, 0);
        frame();
        chk("serve_t2_play_en", play_en, 0);
        chk("serve_t2_state", state_o, S_SERVE);
        frame();
        chk("serve_t3_play_en", play_en, 1);
        chk("serve_t3_state", state_o, S_PLAY);
        chk("play_ball_reset", ball_reset, 0);

        // 3: right miss scores for left
        pulse_miss(1'b0, 1'b1);
        chk("missr_score_l", score_l, 1);
        chk("missr_score_r", score_r, 0);
        chk("missr_dir", serve_dir, 1);
        chk("missr_state", state_o, S_POINT);
        frame();
        chk("hold_t1_state", state_o, S_POINT);
        frame();
        chk("hold_t2_state", state_o, S_SERVE);
        frames(2);
        chk("reserve_t2_state", state_o, S_SERVE);
        frame();
        chk("reserve_t3_state", state_o, S_PLAY);

        // 4: double miss is a replay with no score change
        pulse_miss(1'b1, 1'b1);
        chk("dbl_state", state_o, S_SERVE);
        chk("dbl_score_l", score_l, 1);
        chk("dbl_score_r", score_r, 0);
        chk("dbl_dir", serve_dir, 1);
        frames(3);
        chk("dbl_replay_state", state_o, S_PLAY);

        // 5: left reaches WIN_SCORE
        pulse_miss(1'b0, 1'b1);
        chk("win_score_l", score_l, 2);
        frames(2);
        chk("over_state", state_o, S_OVER);
        chk("over_winner", winner, 1);
        chk("over_ball_reset", ball_reset, 1);
        pulse_miss(1'b1, 1'b0);
        pulse_miss(1'b0, 1'b1);
        chk("over_miss_score_l", score_l, 2);
        chk("over_miss_score_r", score_r, 0);
        restart();
        chk("re_state", state_o, S_SERVE);
        chk("re_score_l", score_l, 0);
        chk("re_winner", winner, 0);
        chk("re_dir", serve_dir, 0);

        // 6: reach 1-1 in PLAY, check no mid-match restart, then reset
        frames(3);
        pulse_miss(1'b0, 1'b1);
        frames(5);
        pulse_miss(1'b1, 1'b0);
        chk("ll_score_r", score_r, 1);
        chk("ll_dir", serve_dir, 0);
        frames(5);
        chk("ll_state", state_o, S_PLAY);
        restart();
        chk("no_midrestart_state", state_o, S_PLAY);
        chk("no_midrestart_score", score_l, 1);
        @(negedge clk);
        game_rst = 1'b1;
        @(negedge clk);
        game_rst = 1'b0;
        chk("mid_rst_state", state_o, S_IDLE);
        chk("mid_rst_score_l", score_l, 0);
        chk("mid_rst_score_r", score_r, 0);
        chk("mid_rst_play_en", play_en, 0);
        chk("mid_rst_winner", winner, 0);
        pulse_miss(1'b1, 1'b0);
        frame();
        chk("idle_miss_score_r", score_r, 0);
        chk("idle_hold_state", state_o, S_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
